// File: rtl/regfile_rd_port.sv
// Integer register file: two combinational read ports, one valid/ready write port, x0 hardwired to zero.
// Latency: reads are zero-latency; writes are visible next cycle (same cycle with RF_BYPASS_EN defined).
// Backpressure: wr_ready stays low during the post-reset clearing sweep, then high permanently.
module regfile_rd_port #(
  parameter int Width   = 32,
  parameter int NumRegs = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic [Width-1:0] rs1_data,
  output logic [Width-1:0] rs2_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [4:0]       rd,
  input  logic [Width-1:0] rd_data,
  output logic             ready
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [4:0] LastPtr = 5'(NumRegs - 1);

  state_t           state;
  logic [4:0]       ptr;
  logic [Width-1:0] mem [1:NumRegs-1];
  logic             wr_fire;
  logic             wr_hit;

  function automatic logic in_range(input logic [4:0] addr);
    return (addr != 5'd0) && (int'(addr) < NumRegs);
  endfunction

  assign wr_fire = wr_valid && wr_ready;
  assign wr_hit  = wr_fire && in_range(rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      ptr      <= 5'd1;
      ready    <= 1'b0;
      wr_ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (ptr == LastPtr) begin
            state    <= RUN;
            ready    <= 1'b1;
            wr_ready <= 1'b1;
          end else begin
            ptr <= ptr + 5'd1;
          end
        end
        RUN: begin
          ready    <= 1'b1;
          wr_ready <= 1'b1;
        end
        default: begin
          state    <= INIT;
          ptr      <= 5'd1;
          ready    <= 1'b0;
          wr_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage carries no reset net; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[ptr] <= '0;
    end else if (wr_hit) begin
      mem[rd] <= rd_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (ready) begin
`ifdef RF_BYPASS_EN
      if (wr_hit && rd == rs1) rs1_data = rd_data;
      else if (in_range(rs1)) rs1_data = mem[rs1];
      if (wr_hit && rd == rs2) rs2_data = rd_data;
      else if (in_range(rs2)) rs2_data = mem[rs2];
`else
      if (in_range(rs1)) rs1_data = mem[rs1];
      if (in_range(rs2)) rs2_data = mem[rs2];
`endif
    end
  end

endmodule

// File: tb/tb_regfile_rd_port.sv
// Scoreboard bench for regfile_rd_port: random and directed traffic against a register-array model.
module tb_regfile_rd_port;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data, rd_data;
  logic        wr_valid, wr_ready, ready;

  regfile_rd_port #(.Width(32), .NumRegs(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd       (rd),
    .rd_data  (rd_data),
    .ready    (ready)
  );

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        rdy;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [32];
  int          cnt_run;
  int          errors;
  int          checks;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Model: the file is usable once 31 clock edges have passed with rst_n high.
  function automatic logic [31:0] model_read(input logic [4:0] a, input logic rdy,
                                             input logic acc, input logic [4:0] wa,
                                             input logic [31:0] wd);
    if (!rdy || a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (acc && wa != 5'd0 && wa == a) return wd;
`endif
    return ref_mem[a];
  endfunction

  // Called at posedge+1: drive one cycle of stimulus, queue expectation, advance the model.
  task automatic step(input logic [4:0] a1, input logic [4:0] a2, input logic wv,
                      input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    logic rdy, acc;
    rs1 = a1; rs2 = a2; wr_valid = wv; rd = wa; rd_data = wd;
    rdy  = rst_n && (cnt_run >= 31);
    acc  = wv && rdy;
    e.d1  = model_read(a1, rdy, acc, wa, wd);
    e.d2  = model_read(a2, rdy, acc, wa, wd);
    e.rdy = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      cnt_run = 0;
      foreach (ref_mem[i]) ref_mem[i] = 32'd0;
    end else begin
      if (acc && wa != 5'd0) ref_mem[wa] = wd;
      cnt_run++;
    end
    #1;
  endtask

  // Monitor: outputs are settled by the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rs1_data", rs1_data, e.d1);
        chk("rs2_data", rs2_data, e.d2);
        chk("ready", {31'd0, ready}, {31'd0, e.rdy});
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, e.rdy});
      end
    end
  end

  initial begin
    errors = 0; checks = 0; cnt_run = 0;
    foreach (ref_mem[i]) ref_mem[i] = 32'd0;
    rst_n = 1'b0; rs1 = '0; rs2 = '0; wr_valid = 1'b0; rd = '0; rd_data = '0;
    @(posedge clk); #1;

    // Reset held: everything reads zero.
    for (int i = 0; i < 3; i++) step(5'd5, 5'd9, 1'b1, 5'd3, 32'hFFFF_FFFF);
    rst_n = 1'b1;

    // INIT sweep with rs1=5, plus a write to x9 at cycle 10 that must be ignored.
    for (int i = 0; i < 31; i++) step(5'd5, 5'd9, (i == 10), 5'd9, 32'h55);
    step(5'd5, 5'd9, 1'b0, 5'd0, 32'd0);
    step(5'd9, 5'd5, 1'b0, 5'd0, 32'd0);

    // Basic write then dual read.
    step(5'd0, 5'd0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    step(5'd3, 5'd3, 1'b0, 5'd0, 32'd0);

    // Write to x0 accepted but discarded, concurrent x0 read.
    step(5'd0, 5'd0, 1'b1, 5'd0, 32'h1234_5678);
    step(5'd0, 5'd3, 1'b0, 5'd0, 32'd0);

    // Same-cycle write/read hazard on x7.
    step(5'd1, 5'd1, 1'b1, 5'd7, 32'h11);
    step(5'd3, 5'd7, 1'b1, 5'd7, 32'hA5A5_A5A5);
    step(5'd7, 5'd7, 1'b0, 5'd0, 32'd0);

    // Randomised traffic, biased so writes often collide with reads.
    for (int i = 0; i < 300; i++) begin
      logic [4:0]  a1, a2, wa;
      a1 = 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 2) == 0) ? a2 : 5'($urandom_range(0, 31));
      step(a1, a2, 1'($urandom_range(0, 1)), wa, $urandom);
    end

    // Write x4, then pull reset asynchronously in the following cycle.
    step(5'd4, 5'd3, 1'b1, 5'd4, 32'h44);
    step(5'd4, 5'd4, 1'b0, 5'd0, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    wr_valid = 1'b1; rd = 5'd4; rd_data = 32'hBAD0_BAD0;
    #1;
    chk("async_rst_ready", {31'd0, ready}, 32'd0);
    chk("async_rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("async_rst_rs1", rs1_data, 32'd0);
    @(posedge clk); #1;
    cnt_run = 0;
    foreach (ref_mem[i]) ref_mem[i] = 32'd0;
    step(5'd4, 5'd3, 1'b1, 5'd4, 32'h77);
    rst_n = 1'b1;
    for (int i = 0; i < 31; i++) step(5'd4, 5'd3, 1'b1, 5'd4, 32'h99);
    step(5'd4, 5'd3, 1'b0, 5'd0, 32'd0);
    for (int r = 1; r < 32; r++) step(5'(r), 5'(31 - r), 1'b0, 5'd0, 32'd0);

    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
